// File: rtl/exp4_sensor_dist.sv
// HC-SR04 range finder: trigger pulse, echo timing, rounded cm count, BCD and 7-segment outputs.
// Optional echo watchdog and erro state are built in when ECHO_TIMEOUT_EN is defined.
//
// state          | meaning
// inicial        | idle, waiting for a medir rising edge
// preparacao     | clear remainder/accumulator, load trigger timer
// envia_trigger  | trigger high for TRIGGER_CYCLES clocks
// espera_echo    | waiting for echo high (counts if already high)
// medida         | counting clocks while echo is high
// armazenamento  | round and load medida
// final_medida   | pronto pulse
// erro           | watchdog expired, medida = 999 (ECHO_TIMEOUT_EN only)
module exp4_sensor_dist #(
    parameter int unsigned TRIGGER_CYCLES = 500,
    parameter int unsigned CM_CYCLES      = 2941,
    parameter int unsigned HALF_CM_CYCLES = 1470,
    parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        medir,
    input  logic        echo,
    output logic [11:0] medida,
    output logic        trigger,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic        pronto,
    output logic        db_medir,
    output logic        db_echo,
    output logic        db_trigger,
    output logic [6:0]  db_estado
);

    localparam int TW = (TRIGGER_CYCLES > 1) ? $clog2(TRIGGER_CYCLES) : 1;
    localparam int RW = (CM_CYCLES > 1) ? $clog2(CM_CYCLES) : 1;
    localparam logic [TW-1:0] TRIG_LAST = TW'(TRIGGER_CYCLES - 1);
    localparam logic [RW-1:0] CM_LAST   = RW'(CM_CYCLES - 1);
    localparam logic [RW-1:0] HALF      = RW'(HALF_CM_CYCLES);

    if (TRIGGER_CYCLES < 1 || CM_CYCLES < 2 || HALF_CM_CYCLES >= CM_CYCLES
        || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("exp4_sensor_dist: inconsistent timing parameters");
    end

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARACAO    = 4'h1,
        ENVIA_TRIGGER = 4'h2,
        ESPERA_ECHO   = 4'h3,
        MEDIDA        = 4'h4,
        ARMAZENAMENTO = 4'h5,
`ifdef ECHO_TIMEOUT_EN
        ERRO          = 4'hE,
`endif
        FINAL_MEDIDA  = 4'hF
    } state_t;

    state_t        state, state_next;
    logic          medir_q;
    logic          start;
    logic [TW-1:0] trig_cnt;
    logic [RW-1:0] rem_cnt;
    logic [11:0]   acc;

`ifdef ECHO_TIMEOUT_EN
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);
    logic [WW-1:0] wdog_cnt;
`endif

    // BCD +1 with the carry chain stopping at 999
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != 12'h999) begin
            if (v[3:0] != 4'd9) begin
                r[3:0] = v[3:0] + 4'd1;
            end else begin
                r[3:0] = 4'd0;
                if (v[7:4] != 4'd9) begin
                    r[7:4] = v[7:4] + 4'd1;
                end else begin
                    r[7:4]  = 4'd0;
                    r[11:8] = v[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    // active-low, gfedcba
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign start = medir & ~medir_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= INICIAL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        trigger    = (state == ENVIA_TRIGGER);
        pronto     = (state == FINAL_MEDIDA);
`ifdef ECHO_TIMEOUT_EN
        if (state == ERRO) pronto = 1'b1;
`endif
        case (state)
            INICIAL:       if (start) state_next = PREPARACAO;
            PREPARACAO:    state_next = ENVIA_TRIGGER;
            ENVIA_TRIGGER: if (trig_cnt == '0) state_next = ESPERA_ECHO;
            ESPERA_ECHO: begin
                if (echo) state_next = MEDIDA;
`ifdef ECHO_TIMEOUT_EN
                if (wdog_cnt == '0) state_next = ERRO;
`endif
            end
            MEDIDA: begin
                if (!echo) state_next = ARMAZENAMENTO;
`ifdef ECHO_TIMEOUT_EN
                if (wdog_cnt == '0) state_next = ERRO;
`endif
            end
            ARMAZENAMENTO: state_next = FINAL_MEDIDA;
            default:       state_next = INICIAL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            medir_q  <= 1'b0;
            trig_cnt <= '0;
            rem_cnt  <= '0;
            acc      <= 12'h000;
            medida   <= 12'h000;
`ifdef ECHO_TIMEOUT_EN
            wdog_cnt <= '0;
`endif
        end else begin
            medir_q <= medir;
            case (state)
                PREPARACAO: begin
                    trig_cnt <= TRIG_LAST;
                    rem_cnt  <= '0;
                    acc      <= 12'h000;
`ifdef ECHO_TIMEOUT_EN
                    wdog_cnt <= WDOG_LAST;
`endif
                end
                ENVIA_TRIGGER: begin
                    if (trig_cnt != '0) trig_cnt <= trig_cnt - TW'(1);
                end
                ESPERA_ECHO, MEDIDA: begin
`ifdef ECHO_TIMEOUT_EN
                    // loaded here so the error code is already visible while pronto is high
                    if (wdog_cnt == '0) medida <= 12'h999;
                    else                wdog_cnt <= wdog_cnt - WW'(1);
`endif
                    if (echo) begin
                        if (rem_cnt == CM_LAST) begin
                            rem_cnt <= '0;
                            acc     <= bcd_inc(acc);
                        end else begin
                            rem_cnt <= rem_cnt + RW'(1);
                        end
                    end
                end
                ARMAZENAMENTO: begin
                    medida <= (rem_cnt >= HALF) ? bcd_inc(acc) : acc;
                end
                default: ;
            endcase
        end
    end

    assign hex0       = seg7(medida[3:0]);
    assign hex1       = seg7(medida[7:4]);
    assign hex2       = seg7(medida[11:8]);
    assign db_medir   = medir;
    assign db_echo    = echo;
    assign db_trigger = trigger;
    assign db_estado  = seg7(state);

endmodule

// File: tb/tb_exp4_sensor_dist.sv
// Randomized bench for exp4_sensor_dist against a divide-and-round reference model.
// Uses a short centimetre period so long distances fit in a small cycle budget.
module tb_exp4_sensor_dist;

    localparam int TRIG = 500;
    localparam int CM   = 16;
    localparam int HALF = 8;
    localparam int TMO  = 25000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        medir = 1'b0;
    logic        echo  = 1'b0;
    logic [11:0] medida;
    logic        trigger, pronto, db_medir, db_echo, db_trigger;
    logic [6:0]  hex0, hex1, hex2, db_estado;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] last_medida = 12'h000;
    logic [6:0]  seg_tab [16];
    int          k;

    always #10 clock = ~clock;

    exp4_sensor_dist #(
        .TRIGGER_CYCLES (TRIG),
        .CM_CYCLES      (CM),
        .HALF_CM_CYCLES (HALF),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .medir      (medir),
        .echo       (echo),
        .medida     (medida),
        .trigger    (trigger),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2),
        .pronto     (pronto),
        .db_medir   (db_medir),
        .db_echo    (db_echo),
        .db_trigger (db_trigger),
        .db_estado  (db_estado)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // round(n / CM) with ties decided by remainder >= HALF, capped at 999, as BCD
    function automatic logic [11:0] ref_bcd(input int n);
        int q, r, d;
        q = n / CM;
        r = n % CM;
        d = (q > 999) ? 999 : q;
        if (r >= HALF && d < 999) d++;
        return {4'(d / 100), 4'((d / 10) % 10), 4'(d % 10)};
    endfunction

    task automatic measure(input int n, input int dly, input bit reedge);
        logic [11:0] exp;
        int cyc, first, width, mirror_bad, w, trig_seen;
        exp = ref_bcd(n);
        cyc = 0; first = -1; width = 0; mirror_bad = 0;
        @(negedge clock);
        medir = 1'b1;
        #1 chk("db_medir", db_medir, 1);
        while (cyc < 1000 && !(first >= 0 && !trigger)) begin
            @(negedge clock);
            cyc++;
            if (trigger) begin
                if (first < 0) first = cyc;
                width++;
            end
            if (db_trigger !== trigger) mirror_bad++;
            if (cyc == 5) medir = 1'b0;
            if (reedge && cyc == 40) medir = 1'b1;
            if (reedge && cyc == 42) medir = 1'b0;
        end
        medir = 1'b0;
        chk("trig_start", (first >= 1 && first <= 3), 1);
        chk("trig_width", width, TRIG);
        chk("db_trigger", mirror_bad, 0);
        repeat (dly) @(negedge clock);
        echo = 1'b1;
        #1 chk("db_echo", db_echo, 1);
        repeat (n) @(negedge clock);
        chk("medida_hold", medida, last_medida);
        echo = 1'b0;
        w = 0;
        while (!pronto && w < 20) begin
            @(negedge clock);
            w++;
        end
        chk("pronto_seen", pronto, 1);
        chk("medida", medida, exp);
        chk("hex0", hex0, seg_tab[exp[3:0]]);
        chk("hex1", hex1, seg_tab[exp[7:4]]);
        chk("hex2", hex2, seg_tab[exp[11:8]]);
        @(negedge clock);
        chk("pronto_1cyc", pronto, 0);
        chk("back_idle", db_estado, seg_tab[0]);
        last_medida = exp;
        if (reedge) begin
            trig_seen = 0;
            repeat (600) begin
                @(negedge clock);
                if (trigger) trig_seen++;
            end
            chk("no_retrigger", trig_seen, 0);
        end
    endtask

    task automatic start_and_pass_trigger();
        @(negedge clock);
        medir = 1'b1;
        repeat (5) @(negedge clock);
        medir = 1'b0;
        k = 0;
        while (trigger && k < 1000) begin
            @(negedge clock);
            k++;
        end
    endtask

    initial begin
        #(150000 * 20);
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        repeat (10) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_medida", medida, 12'h000);
        chk("rst_trigger", trigger, 0);
        chk("rst_pronto", pronto, 0);
        chk("rst_hex0", hex0, 7'b1000000);
        chk("rst_hex1", hex1, 7'b1000000);
        chk("rst_hex2", hex2, 7'b1000000);
        chk("rst_estado", db_estado, 7'b1000000);
        chk("rst_db_medir", db_medir, 0);
        chk("rst_db_echo", db_echo, 0);

        measure(100 * CM + 5, 0, 1'b1);
        measure(74 * CM + 12, 3, 1'b0);
        measure(170 * CM + 1, 7, 1'b0);
        measure(HALF - 1, 0, 1'b0);
        measure(HALF, 0, 1'b0);
        measure(1000 * CM + 9, 2, 1'b0);
        for (int i = 0; i < 8; i++)
            measure(int'($urandom_range(1, 2000)), int'($urandom_range(0, 30)), 1'b0);

        // reset while the trigger pulse is high
        @(negedge clock);
        medir = 1'b1;
        repeat (5) @(negedge clock);
        medir = 1'b0;
        repeat (50) @(negedge clock);
        chk("trig_before_rst", trigger, 1);
        #3 reset = 1'b1;
        #1;
        chk("rst1_trigger", trigger, 0);
        chk("rst1_medida", medida, 12'h000);
        chk("rst1_estado", db_estado, seg_tab[0]);
        @(negedge clock);
        reset = 1'b0;
        last_medida = 12'h000;

        // reset while counting echo
        measure(37 * CM + 3, 1, 1'b0);
        start_and_pass_trigger();
        echo = 1'b1;
        repeat (100) @(negedge clock);
        chk("in_medida", db_estado, seg_tab[4]);
        #3 reset = 1'b1;
        #1;
        chk("rst2_trigger", trigger, 0);
        chk("rst2_medida", medida, 12'h000);
        chk("rst2_estado", db_estado, seg_tab[0]);
        echo = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        last_medida = 12'h000;
        measure(55 * CM + HALF, 4, 1'b0);

        // request with no echo at all
        start_and_pass_trigger();
`ifdef ECHO_TIMEOUT_EN
        k = 0;
        while (!pronto && k < TMO + 100) begin
            @(negedge clock);
            k++;
        end
        chk("tmo_pronto", pronto, 1);
        chk("tmo_cycles", k, TMO);
        chk("tmo_medida", medida, 12'h999);
        chk("tmo_estado", db_estado, seg_tab[14]);
        @(negedge clock);
        chk("tmo_pronto_1cyc", pronto, 0);
        chk("tmo_idle", db_estado, seg_tab[0]);
`else
        k = 0;
        repeat (300) begin
            @(negedge clock);
            if (pronto) k++;
        end
        chk("wait_no_pronto", k, 0);
        chk("wait_estado", db_estado, seg_tab[3]);
        chk("wait_medida", medida, last_medida);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exp4_sensor_dist.md
Name: exp4_sensor_dist

Overview:
- HC-SR04 ultrasonic range-finder interface on a 50 MHz system clock.
- On a `medir` request it issues a 10 µs trigger pulse and times the returned `echo` pulse.
- It converts the echo width to centimetres, rounded to nearest, and outputs the result as 3 BCD digits plus three active-low 7-segment displays, with debug taps for the board.

Parameters:
- TRIGGER_CYCLES, 500: trigger pulse width in clocks (10 µs @ 50 MHz).
- CM_CYCLES, 2941: clocks per centimetre (58.82 µs).
- HALF_CM_CYCLES, 1470: rounding threshold on the remainder.
- TIMEOUT_CYCLES, 2_500_000: echo watchdog (50 ms); used only with the optional feature.

Ports:
- clock  in  1  system clock, 50 MHz, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- medir  in  1  measurement request, level; its rising edge starts a measurement.
- echo  in  1  sensor echo pulse.
- medida  out  12  BCD distance in cm, [11:8] hundreds, [7:4] tens, [3:0] units.
- trigger  out  1  sensor trigger pulse.
- hex0  out  7  7-segment display of medida[3:0].
- hex1  out  7  7-segment display of medida[7:4].
- hex2  out  7  7-segment display of medida[11:8].
- pronto  out  1  measurement done, 1-cycle pulse.
- db_medir  out  1  copy of medir.
- db_echo  out  1  copy of echo.
- db_trigger  out  1  copy of trigger.
- db_estado  out  7  7-segment display of the FSM state code.

Behaviour:
- Clocking and reset: one clock domain; reset is asynchronous and active-high (fixed).
- Reset values: medida=0x000, trigger=0, pronto=0, FSM=inicial, all counters 0; hex0..2 show "0"; db_estado shows "0".
- Request edge detect: medir is registered; start = medir & ~medir_q.
  - A held or multi-cycle medir yields exactly one measurement.
  - medir edges are ignored unless the FSM is in inicial.
- FSM states, with their db_estado codes:
  - inicial (0): wait for start.
  - preparacao (1): clear tick counter, remainder counter and BCD accumulator; 1 cycle.
  - envia_trigger (2): trigger=1 for exactly TRIGGER_CYCLES clocks, then go to espera_echo.
  - espera_echo (3): wait for echo=1.
  - medida (4): while echo=1, count clocks.
    - The remainder counter runs 0..CM_CYCLES-1.
    - Each wrap increments the BCD accumulator by 1 (units/tens/hundreds carry chain).
    - The accumulator saturates at 999.
    - On echo=0, go to armazenamento.
  - armazenamento (5): if remainder >= HALF_CM_CYCLES, increment the accumulator once more (still saturating); load medida with the accumulator.
  - final_medida (F): pronto=1 for one cycle, then go to inicial.
- medida holds its value until the next armazenamento; it is never cleared mid-measurement.
- Rounding: distance = round(echo_clocks / CM_CYCLES).
  - 5899 µs gives 100; 4399 µs gives 75; 10000 µs gives 170.
- echo is used directly; the bench drives it synchronously and there is no synchronizer requirement.
- 7-segment encoding is active-low, gfedcba order.
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110.
- db outputs are combinational copies; db_estado uses the same encoder on the 4-bit state code.
- Reset mid-operation: immediate return to the reset values, with trigger dropping at once.
- echo already high on entry to espera_echo: the count starts on the first cycle there.
- echo pulse shorter than HALF_CM_CYCLES: medida=0x000.

Optional Feature:
- Macro ECHO_TIMEOUT_EN.
- When defined, a watchdog counts clocks in espera_echo and medida.
  - If TIMEOUT_CYCLES is reached, the FSM enters erro (code E): medida is loaded with 0x999 and pronto pulses for 1 cycle.
  - The FSM then returns to inicial.
- When undefined, there is no watchdog: the FSM waits in espera_echo/medida indefinitely and the erro state does not exist.

Test Plan:
- Reset 200 ns -> medida=0x000, trigger=0, pronto=0, hex0..2=1000000, db_estado=1000000.
- medir high 5 cycles -> exactly one trigger pulse of 500 clocks, starting within 3 cycles; db_trigger mirrors it; second edge during busy ignored.
- Echo 5899 µs, 20 µs after medir -> pronto 1-cycle pulse after echo falls; medida=0x100; hex2=1111001, hex1=hex0=1000000.
- Echo 4399 µs -> medida=0x075 (rounded up from 74.79); hex1=1111000, hex0=0010010.
- Echo 10000 µs -> medida=0x170; then medir with no echo: with ECHO_TIMEOUT_EN, after 50 ms medida=0x999 and pronto pulses; without it, FSM stays in state 3.
- Reset asserted during medida state -> trigger=0, medida=0x000, FSM=inicial immediately; new medir works normally.
